// File: rtl/ov7670_config_ctrl.sv
// OV7670 register configuration sequencer: walks a ROM of {reg, value} words and
// drives an SCCB master with 3-byte writes, with retries, delay entries and timeouts.
module ov7670_config_ctrl #(
  parameter int CLK_F       = 100_000_000,
  parameter int DELAY_CYC   = CLK_F / 100,
  parameter int TIMEOUT_CYC = CLK_F / 1000,
  parameter int MAX_RETRY   = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_cfg_start,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic        o_start,
  output logic        o_write,
  output logic        o_read,
  output logic        o_stop,
  output logic        o_restart,
  output logic [7:0]  o_addr,
  output logic [7:0]  o_din,
  input  logic        i_ready,
  input  logic        i_done,
  input  logic        i_ack,
  output logic        o_busy,
  output logic        o_cfg_done,
  output logic        o_err,
  output logic [7:0]  o_err_addr
);

  localparam int DW = $clog2(DELAY_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_XFER, S_SETTLE, S_DELAY, S_DONE, S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      rom_addr_q, rom_addr_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      din_q, din_d;
  logic            err_q, err_d;
  logic [7:0]      err_addr_q, err_addr_d;
  logic            start_q, start_d;
  logic [1:0]      dcnt_q, dcnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            nack_q, nack_d;
  logic            ack_pend_q, ack_pend_d;
  logic [DW-1:0]   dly_q, dly_d;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      start_q    <= 1'b0;
      dcnt_q     <= '0;
      tmo_q      <= '0;
      retry_q    <= '0;
      nack_q     <= 1'b0;
      ack_pend_q <= 1'b0;
      dly_q      <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      start_q    <= start_d;
      dcnt_q     <= dcnt_d;
      tmo_q      <= tmo_d;
      retry_q    <= retry_d;
      nack_q     <= nack_d;
      ack_pend_q <= ack_pend_d;
      dly_q      <= dly_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    addr_d     = addr_q;
    din_d      = din_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    start_d    = 1'b0;
    dcnt_d     = dcnt_q;
    tmo_d      = tmo_q;
    retry_d    = retry_q;
    nack_d     = nack_q;
    dly_d      = dly_q;
    // ACK bit arrives the cycle after each done tick; the last one lands in SETTLE
    ack_pend_d = (state_q == S_XFER) && i_done;
    if (ack_pend_q && i_ack) nack_d = 1'b1;

    case (state_q)
      S_IDLE: if (i_cfg_start) begin
        state_d    = S_FETCH;
        rom_addr_d = '0;
        retry_d    = '0;
        err_d      = 1'b0;
        err_addr_d = '0;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (i_rom_data == 16'hFFFF) state_d = S_DONE;
        else if (i_rom_data == 16'hFFF0) begin
          state_d = S_DELAY;
          dly_d   = DW'(DELAY_CYC - 1);
        end else begin
          addr_d  = i_rom_data[15:8];
          din_d   = i_rom_data[7:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (i_ready) begin
        start_d = 1'b1;
        dcnt_d  = '0;
        tmo_d   = '0;
        nack_d  = 1'b0;
        state_d = S_XFER;
      end
      S_XFER: begin
        tmo_d = TW'(tmo_q + 1'b1);
        if (i_done) begin
          dcnt_d = dcnt_q + 2'd1;
          if (dcnt_q == 2'd2) state_d = S_SETTLE;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          nack_d  = 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: if (i_ready && !ack_pend_q) begin
        if (!nack_q) begin
          retry_d = '0;
          if (rom_addr_q == 8'hFF) state_d = S_DONE;
          else begin
            rom_addr_d = rom_addr_q + 8'd1;
            state_d    = S_FETCH;
          end
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = S_ISSUE;
        end else begin
          err_d      = 1'b1;
          err_addr_d = rom_addr_q;
          state_d    = S_FAIL;
        end
      end
      S_DELAY: begin
        if (dly_q == '0) begin
          if (rom_addr_q == 8'hFF) state_d = S_DONE;
          else begin
            rom_addr_d = rom_addr_q + 8'd1;
            state_d    = S_FETCH;
          end
        end else dly_d = dly_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_rom_addr = rom_addr_q;
  assign o_addr     = addr_q;
  assign o_din      = din_q;
  assign o_start    = start_q;
  assign o_write    = (state_q == S_XFER);
  assign o_read     = 1'b0;
  assign o_stop     = 1'b0;
  assign o_restart  = 1'b0;
  assign o_busy     = (state_q != S_IDLE);
  assign o_cfg_done = (state_q == S_DONE);
  assign o_err      = err_q;
  assign o_err_addr = err_addr_q;

endmodule

// File: tb/tb_ov7670_config_ctrl.sv
// Bench for ov7670_config_ctrl: ROM + SCCB master model, scoreboard of expected
// writes, table of configuration scenarios plus reset and address-limit sequences.
module tb_ov7670_config_ctrl;

  logic        clk = 1'b0;
  logic        i_rstn, i_cfg_start;
  logic [7:0]  o_rom_addr;
  logic [15:0] i_rom_data;
  logic        o_start, o_write, o_read, o_stop, o_restart;
  logic [7:0]  o_addr, o_din;
  logic        i_ready, i_done, i_ack;
  logic        o_busy, o_cfg_done, o_err;
  logic [7:0]  o_err_addr;

  always #5 clk = ~clk;

  ov7670_config_ctrl #(.DELAY_CYC(50), .TIMEOUT_CYC(200), .MAX_RETRY(2)) dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_cfg_start(i_cfg_start),
    .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .o_start(o_start), .o_write(o_write), .o_read(o_read), .o_stop(o_stop),
    .o_restart(o_restart), .o_addr(o_addr), .o_din(o_din),
    .i_ready(i_ready), .i_done(i_done), .i_ack(i_ack),
    .o_busy(o_busy), .o_cfg_done(o_cfg_done), .o_err(o_err), .o_err_addr(o_err_addr)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  logic [15:0] rom [256];
  logic [15:0] exp_q [$];

  always @(posedge clk) cyc++;
  always @(posedge clk) i_rom_data <= rom[o_rom_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int lo);
    checks++;
    if (act < lo) begin
      failures++;
      $display("FAIL %s: got %0d expected >= %0d", name, act, lo);
    end
  endtask

  // SCCB master model: 3 done ticks per write, optional NACK on last byte, or silence
  logic [7:0] nack_addr = '0;
  int  nack_left = 0;
  bit  no_done = 1'b0;
  int  mdl_byte = -1;
  initial begin
    bit do_nack;
    i_ready = 1'b1; i_done = 1'b0; i_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (o_start) begin
        i_ready = 1'b0;
        if (no_done) repeat (250) @(posedge clk);
        else begin
          do_nack = (o_addr == nack_addr) && (nack_left > 0);
          if (do_nack) nack_left--;
          for (int b = 0; b < 3; b++) begin
            mdl_byte = b;
            repeat (2) @(posedge clk);
            #1 i_done = 1'b1;
            @(posedge clk); #1 i_done = 1'b0; i_ack = do_nack && (b == 2);
            @(posedge clk); #1 i_ack = 1'b0;
          end
          repeat (2) @(posedge clk);
        end
        #1 i_ready = 1'b1;
      end
    end
  end

  // scoreboard side: every o_start pops one expected {reg, value}
  int n_starts, n_done, last_start, min_gap, first_start;
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (o_start) begin
        n_starts++;
        if (n_starts > 1 && (cyc - last_start) < min_gap) min_gap = cyc - last_start;
        last_start = cyc;
        if (first_start < 0) first_start = cyc;
        if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr_data", {o_addr, o_din}, e);
          chk("wr_write_hi", o_write, 1);
        end
      end
      if (o_cfg_done) n_done++;
    end
  end

  typedef struct {
    logic [3:0][15:0] words;  // words[0] is ROM entry 0 (rightmost in the literal)
    logic [3:0][15:0] expw;
    int nw;
    logic [7:0] nack_addr;
    int nack_n;
    bit no_done;
    bit exp_err;
    logic [7:0] exp_err_addr;
    int exp_done;
    int min_lat;
    int min_gap;
  } vec_t;

  function automatic vec_t mk(logic [63:0] w, logic [63:0] e, int nw, logic [7:0] na,
                              int nn, bit nd, bit ee, logic [7:0] ea, int ed, int ml, int mg);
    vec_t v;
    v.words = w; v.expw = e; v.nw = nw; v.nack_addr = na; v.nack_n = nn; v.no_done = nd;
    v.exp_err = ee; v.exp_err_addr = ea; v.exp_done = ed; v.min_lat = ml; v.min_gap = mg;
    return v;
  endfunction

  task automatic reset_counters();
    n_starts = 0; n_done = 0; min_gap = 1_000_000; first_start = -1; last_start = 0;
    exp_q.delete();
  endtask

  task automatic pulse_start(output int t0);
    @(posedge clk); #1 i_cfg_start = 1'b1; t0 = cyc;
    @(posedge clk); #1 i_cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((o_busy || !i_ready) && n < budget) begin
      @(posedge clk); n++;
    end
    #1 chk("idle_within_budget", int'(n < budget), 1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic run_case(input vec_t t);
    int t0;
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    for (int k = 0; k < 4; k++) rom[k] = t.words[k];
    nack_addr = t.nack_addr; nack_left = t.nack_n; no_done = t.no_done;
    reset_counters();
    for (int k = 0; k < t.nw; k++) exp_q.push_back(t.expw[k]);
    pulse_start(t0);
    wait_idle(5000);
    chk("start_count", n_starts, t.nw);
    chk("sb_leftover", exp_q.size(), 0);
    chk("err", o_err, t.exp_err);
    chk("err_addr", o_err_addr, t.exp_err_addr);
    chk("cfg_done_ticks", n_done, t.exp_done);
    if (t.min_lat > 0) chk_ge("delay_latency", first_start - t0, t.min_lat);
    if (t.min_gap > 0) chk_ge("retry_gap", min_gap, t.min_gap);
  endtask

  vec_t tbl [6];

  initial begin
    int t0;
    tbl[0] = mk({16'hFFFF, 16'hFFFF, 16'h1101, 16'h1280}, {16'h0, 16'h0, 16'h1101, 16'h1280},
                2, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0);
    tbl[1] = mk({16'hFFFF, 16'hFFFF, 16'h3A04, 16'hFFF0}, {16'h0, 16'h0, 16'h0, 16'h3A04},
                1, 8'h00, 0, 0, 0, 8'h00, 1, 53, 0);
    tbl[2] = mk({16'hFFFF, 16'hFFFF, 16'h1101, 16'h1280}, {16'h1101, 16'h1101, 16'h1101, 16'h1280},
                4, 8'h11, 3, 0, 1, 8'h01, 0, 0, 0);
    tbl[3] = mk({16'hFFFF, 16'hFFFF, 16'h1101, 16'h1280}, {16'h0, 16'h1101, 16'h1101, 16'h1280},
                3, 8'h11, 1, 0, 0, 8'h00, 1, 0, 0);
    tbl[4] = mk({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h5501}, {16'h0, 16'h5501, 16'h5501, 16'h5501},
                3, 8'h00, 0, 1, 1, 8'h00, 0, 0, 250);
    tbl[5] = mk({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 64'h0,
                0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0);

    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    reset_counters();
    i_rstn = 1'b0; i_cfg_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {o_rom_addr, o_addr, o_din, o_err_addr, o_start, o_write, o_read,
                        o_stop, o_restart, o_cfg_done, o_err}, 0);
    chk("rst_busy", o_busy, 0);
    i_rstn = 1'b1;
    repeat (2) @(posedge clk);

    for (int c = 0; c < 6; c++) run_case(tbl[c]);

    // non-terminated ROM: must stop after entry 0xFF without wrapping to 0
    no_done = 1'b0; nack_left = 0;
    reset_counters();
    for (int i = 0; i < 256; i++) begin
      rom[i] = {i[7:0], ~i[7:0]};
      exp_q.push_back({i[7:0], ~i[7:0]});
    end
    pulse_start(t0);
    wait_idle(20000);
    chk("full_rom_starts", n_starts, 256);
    chk("full_rom_done", n_done, 1);
    chk("full_rom_err", o_err, 0);
    chk("full_rom_last_addr", o_rom_addr, 8'hFF);

    // one-cycle reset during the second byte of a write
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280; rom[1] = 16'h1101;
    reset_counters();
    exp_q.push_back(16'h1280);
    mdl_byte = -1;
    pulse_start(t0);
    begin
      int n = 0;
      while (mdl_byte != 1 && n < 500) begin
        @(posedge clk); n++;
      end
      chk("reach_second_byte", int'(n < 500), 1);
    end
    #1 i_rstn = 1'b0;
    @(posedge clk); #1 i_rstn = 1'b1;
    chk("midxfer_rst_outputs", {o_rom_addr, o_addr, o_din, o_err_addr, o_start, o_write,
                                o_cfg_done, o_err}, 0);
    chk("midxfer_rst_busy", o_busy, 0);
    repeat (300) @(posedge clk);
    #1;
    chk("no_start_after_rst", n_starts, 1);
    chk("no_done_after_rst", n_done, 0);
    chk("midxfer_sb_leftover", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
